// File: rtl/alu_result_streamer.sv
// Buffers full-width ALU results in a small FIFO and streams each one to UART_TX as a
// byte frame: optional header, result bytes, optional XOR checksum.
`timescale 1ns/1ps
module alu_result_streamer #(
    parameter int unsigned RESULT_W    = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HEADER_EN   = 1,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int unsigned CHECKSUM_EN = 1,
    parameter int unsigned MSB_FIRST   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RESULT_W-1:0] in_data,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_busy,
    output logic                frame_active,
    output logic [7:0]          frames_sent,
    output logic                overflow
);

    localparam int unsigned NB   = RESULT_W / 8;
    localparam int unsigned FLEN = NB + HEADER_EN + CHECKSUM_EN;
    localparam int unsigned CW   = $clog2(NB + 2);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_GAP, S_WAIT} state_t;

    // ---------------- result FIFO ----------------
    logic [RESULT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;
    logic                overflow_q;
    logic                push, pop, fifo_empty;

    assign in_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (in_valid && !in_ready) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // ---------------- frame sequencer ----------------
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RESULT_W-1:0] shreg_q, shreg_d;
    logic [7:0]          csum_q, csum_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                frame_active_q, frame_active_d;
    logic [7:0]          frames_q, frames_d;
    logic                is_hdr, is_ck;
    logic [7:0]          data_byte, cur_byte;

    // Byte position is implied by the down-counter: top value is the header, zero the checksum.
    assign is_hdr    = (HEADER_EN != 0) && (cnt_q == CNT_LOAD);
    assign is_ck     = (CHECKSUM_EN != 0) && (cnt_q == '0);
    assign data_byte = (MSB_FIRST != 0) ? shreg_q[RESULT_W-1 -: 8] : shreg_q[7:0];
    assign cur_byte  = is_hdr ? HEADER_BYTE : (is_ck ? csum_q : data_byte);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        csum_d         = csum_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        frame_active_d = frame_active_q;
        frames_d       = frames_q;
        pop            = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    shreg_d        = mem_q[rd_ptr_q];
                    csum_d         = '0;
                    cnt_d          = CNT_LOAD;
                    frame_active_d = 1'b1;
                    state_d        = S_START;
                end
            end
            S_START: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    if (!is_hdr && !is_ck) begin
                        csum_d  = csum_q ^ data_byte;
                        shreg_d = (MSB_FIRST != 0) ? (shreg_q << 8) : (shreg_q >> 8);
                    end
                    state_d = S_GAP;
                end
            end
            S_GAP: state_d = S_WAIT;
            S_WAIT: begin
                if (!tx_busy) begin
                    if (cnt_q == '0) begin
                        frames_d       = frames_q + 8'd1;
                        frame_active_d = 1'b0;
                        state_d        = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            shreg_q        <= '0;
            csum_q         <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            frame_active_q <= 1'b0;
            frames_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            csum_q         <= csum_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
            frame_active_q <= frame_active_d;
            frames_q       <= frames_d;
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign frame_active = frame_active_q;
    assign frames_sent  = frames_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_alu_result_streamer.sv
// Bench for alu_result_streamer: default build plus a 32-bit LSB-first raw build,
// each driving a simple UART_TX busy model; bytes checked against a queue scoreboard.
`timescale 1ns/1ps
module tb_alu_result_streamer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        force_busy = 1'b0;

    logic        in_valid1 = 1'b0, in_ready1, tx_start1, tx_busy1, frame_active1, overflow1;
    logic [15:0] in_data1 = '0;
    logic [7:0]  tx_data1, frames_sent1;

    logic        in_valid2 = 1'b0, in_ready2, tx_start2, tx_busy2, frame_active2, overflow2;
    logic [31:0] in_data2 = '0;
    logic [7:0]  tx_data2, frames_sent2;

    int unsigned bcnt1 = 0, bcnt2 = 0;
    logic        busy_smp1 = 1'b0, busy_smp2 = 1'b0;
    int          starts1 = 0;
    int          vectors = 0, errors = 0;
    logic [7:0]  q1[$], q2[$];

    always #5 clock = ~clock;

    alu_result_streamer u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .tx_start(tx_start1), .tx_data(tx_data1), .tx_busy(tx_busy1),
        .frame_active(frame_active1), .frames_sent(frames_sent1), .overflow(overflow1)
    );

    alu_result_streamer #(
        .RESULT_W(32), .FIFO_DEPTH(4), .HEADER_EN(0), .HEADER_BYTE(8'hA5),
        .CHECKSUM_EN(0), .MSB_FIRST(0)
    ) u_dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .tx_start(tx_start2), .tx_data(tx_data2), .tx_busy(tx_busy2),
        .frame_active(frame_active2), .frames_sent(frames_sent2), .overflow(overflow2)
    );

    // UART_TX stand-in: busy for 10 cycles after each start pulse it sees.
    assign tx_busy1 = (bcnt1 != 0) || force_busy;
    assign tx_busy2 = (bcnt2 != 0);
    initial forever begin
        @(posedge clock);
        busy_smp1 = tx_busy1;
        busy_smp2 = tx_busy2;
        if (tx_start1) bcnt1 <= 10; else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
        if (tx_start2) bcnt2 <= 10; else if (bcnt2 != 0) bcnt2 <= bcnt2 - 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (tx_start1) begin
            starts1++;
            check("start_while_busy1", busy_smp1, 0);
            if (q1.size() == 0) check("extra_byte1", q1.size(), 1);
            else check("byte1", tx_data1, q1.pop_front());
        end
        if (tx_start2) begin
            check("start_while_busy2", busy_smp2, 0);
            if (q2.size() == 0) check("extra_byte2", q2.size(), 1);
            else check("byte2", tx_data2, q2.pop_front());
        end
    end

    task automatic exp_frame1(input logic [15:0] v);
        q1.push_back(8'hA5);
        q1.push_back(v[15:8]);
        q1.push_back(v[7:0]);
        q1.push_back(v[15:8] ^ v[7:0]);
    endtask

    task automatic push1(input logic [15:0] v);
        int unsigned n = 0;
        while (!in_ready1 && n < 3000) begin @(negedge clock); n++; end
        check("push_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        in_data1  = v;
        exp_frame1(v);
        @(negedge clock);
        in_valid1 = 1'b0;
    endtask

    task automatic wait_frames1(input logic [7:0] target, input int unsigned bound);
        int unsigned n = 0;
        while (frames_sent1 !== target && n < bound) begin @(negedge clock); n++; end
        check("frames_sent1", frames_sent1, target);
    endtask

    task automatic wait_idle1(input int unsigned bound);
        int unsigned n = 0;
        while (frame_active1 !== 1'b0 && n < bound) begin @(negedge clock); n++; end
        check("wait_idle1", frame_active1, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        q1.delete();
        q2.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int          s0;
        int unsigned n;

        // reset values
        repeat (3) @(negedge clock);
        check("rst_in_ready", in_ready1, 1);
        check("rst_tx_start", tx_start1, 0);
        check("rst_tx_data", tx_data1, 0);
        check("rst_frame_active", frame_active1, 0);
        check("rst_frames_sent", frames_sent1, 0);
        check("rst_overflow", overflow1, 0);
        reset = 1'b0;

        // 1: default frame and accept-to-start latency
        @(negedge clock);
        in_valid1 = 1'b1;
        in_data1  = 16'h1234;
        q1.push_back(8'hA5); q1.push_back(8'h12); q1.push_back(8'h34); q1.push_back(8'h26);
        @(negedge clock);
        in_valid1 = 1'b0;
        check("lat_cyc1_start", tx_start1, 0);
        check("lat_cyc1_active", frame_active1, 0);
        @(negedge clock);
        check("lat_cyc2_start", tx_start1, 0);
        check("lat_cyc2_active", frame_active1, 1);
        @(negedge clock);
        check("lat_cyc3_start", tx_start1, 1);
        check("lat_first_byte", tx_data1, 8'hA5);
        wait_frames1(8'd1, 1000);
        repeat (5) @(negedge clock);
        check("t1_queue_drained", q1.size(), 0);
        check("t1_idle", frame_active1, 0);

        // 2: 32-bit, LSB first, no header/checksum
        @(negedge clock);
        in_valid2 = 1'b1;
        in_data2  = 32'hDEADBEEF;
        q2.push_back(8'hEF); q2.push_back(8'hBE); q2.push_back(8'hAD); q2.push_back(8'hDE);
        @(negedge clock);
        in_valid2 = 1'b0;
        n = 0;
        while (frames_sent2 !== 8'd1 && n < 1000) begin @(negedge clock); n++; end
        check("t2_frames_sent", frames_sent2, 1);
        repeat (30) @(negedge clock);
        check("t2_queue_drained", q2.size(), 0);
        check("t2_frames_after", frames_sent2, 1);
        check("t2_idle", frame_active2, 0);

        // 3: fill with UART stuck busy, overflow, drain in order
        force_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            v = 16'($urandom_range(0, 65535));
            in_valid1 = 1'b1;
            in_data1  = v;
            check("t3_ready_before_push", in_ready1, (k < 5) ? 1 : 0);
            if (k == 5) check("t3_overflow_before", overflow1, 0);
            if (k < 5) exp_frame1(v);
            @(negedge clock);
        end
        in_valid1 = 1'b0;
        check("t3_overflow_after", overflow1, 1);
        check("t3_full", in_ready1, 0);
        force_busy = 1'b0;
        wait_frames1(8'd6, 4000);
        repeat (5) @(negedge clock);
        check("t3_queue_drained", q1.size(), 0);

        // 4: push+pop at DEPTH-1, then push at full during pop
        do_reset();
        check("t4_overflow_cleared", overflow1, 0);
        check("t4_frames_cleared", frames_sent1, 0);
        force_busy = 1'b1;
        push1(16'hA001);
        @(negedge clock);
        push1(16'hB002);
        push1(16'hC003);
        push1(16'hD004);
        check("t4_count3_ready", in_ready1, 1);
        force_busy = 1'b0;
        wait_idle1(2000);
        in_valid1 = 1'b1;
        in_data1  = 16'hE005;
        exp_frame1(16'hE005);
        @(negedge clock);
        check("t4_pushpop_ready", in_ready1, 1);
        check("t4_pushpop_popped", frame_active1, 1);
        in_data1 = 16'hF006;
        exp_frame1(16'hF006);
        @(negedge clock);
        in_valid1 = 1'b0;
        check("t4_full", in_ready1, 0);
        wait_idle1(2000);
        in_valid1 = 1'b1;
        in_data1  = 16'h7777;
        check("t4_ready_at_full_pop", in_ready1, 0);
        @(negedge clock);
        in_valid1 = 1'b0;
        check("t4_overflow", overflow1, 1);
        check("t4_pop_freed", in_ready1, 1);
        check("t4_popped", frame_active1, 1);
        wait_frames1(8'd6, 5000);
        repeat (5) @(negedge clock);
        check("t4_queue_drained", q1.size(), 0);

        // 5: reset in WAIT of byte 2, then fresh frame
        s0 = starts1;
        push1(16'h5A5A);
        n = 0;
        while (starts1 < s0 + 2 && n < 500) begin @(negedge clock); n++; end
        check("t5_second_start", starts1, s0 + 2);
        @(negedge clock);
        check("t5_mid_frame", frame_active1, 1);
        reset = 1'b1;
        q1.delete();
        @(negedge clock);
        check("t5_rst_tx_start", tx_start1, 0);
        check("t5_rst_tx_data", tx_data1, 0);
        check("t5_rst_active", frame_active1, 0);
        check("t5_rst_frames", frames_sent1, 0);
        check("t5_rst_overflow", overflow1, 0);
        check("t5_rst_ready", in_ready1, 1);
        reset = 1'b0;
        push1(16'h0FF0);
        wait_frames1(8'd1, 1000);
        repeat (5) @(negedge clock);
        check("t5_queue_drained", q1.size(), 0);

        // 6: 256 frames wrap the frame counter
        do_reset();
        for (int k = 0; k < 256; k++) push1(16'($urandom_range(0, 65535)));
        n = 0;
        while ((q1.size() != 0 || frame_active1 !== 1'b0) && n < 5000) begin
            @(negedge clock); n++;
        end
        check("t6_queue_drained", q1.size(), 0);
        check("t6_idle", frame_active1, 0);
        check("t6_frames_wrap", frames_sent1, 0);
        check("t6_no_overflow", overflow1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
